// File: rtl/event_buf_ctrl_if.sv
// Buffer-side bus of the event buffer controller: trigger/L1 inputs,
// downstream backpressure, buffer write/read ports and the output word strobes.
interface event_buf_ctrl_if #(
  parameter int AW = 6
);
  logic          trig_l0;
  logic          l1_accept;
  logic          l1_reject;
  logic          rd_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          rd_valid;
  logic          rd_last;

  modport master (
    input  trig_l0, l1_accept, l1_reject, rd_ready,
    output mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr, rd_valid, rd_last
  );

  modport slave (
    output trig_l0, l1_accept, l1_reject, rd_ready,
    input  mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr, rd_valid, rd_last
  );
endinterface

// File: rtl/event_buf_ctrl.sv
// Event buffer controller: L0 capture, L1 decision, backpressured readout.
// Optional WAIT_L1 timeout enabled by defining EVENT_BUF_CTRL_L1_TIMEOUT_EN.
module event_buf_ctrl #(
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int RD_LAT     = 2,
  parameter int L1_TIMEOUT = 1000,
  parameter int CNT_W      = 16
) (
  input  logic               adc_clk,
  input  logic               rst,
  event_buf_ctrl_if.master   bus,
  output logic               busy,
  output logic               evt_dropped,
  output logic               l1_timeout,
  output logic [CNT_W-1:0]   evt_count,
  output logic [CNT_W-1:0]   drop_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_L1,
    READOUT,
    DRAIN
  } state_t;

  state_t              state;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;
  logic                l1_seen;
  logic                l1_acc;
  logic [RD_LAT-1:0]   valid_pipe;
  logic [RD_LAT-1:0]   last_pipe;
  logic                rd_fire;
  logic                rd_fire_last;
  logic                dec_acc;
  logic                dec_rej;
  logic                l1_pulse;

  assign rd_fire      = (state == READOUT) && bus.rd_ready;
  assign rd_fire_last = rd_fire && (rd_addr == LAST_ADDR);
  assign l1_pulse     = bus.l1_accept || bus.l1_reject;

  // A latched decision always wins over a pulse arriving in WAIT_L1; reject beats accept.
  assign dec_rej = l1_seen ? !l1_acc : bus.l1_reject;
  assign dec_acc = l1_seen ? l1_acc  : (bus.l1_accept && !bus.l1_reject);

  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = wr_addr;
  assign bus.mem_rd_en   = rd_fire;
  assign bus.mem_rd_addr = rd_addr;
  assign bus.rd_valid    = valid_pipe[RD_LAT-1];
  assign bus.rd_last     = last_pipe[RD_LAT-1];

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      valid_pipe[0] <= rd_fire;
      last_pipe[0]  <= rd_fire_last;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

`ifdef EVENT_BUF_CTRL_L1_TIMEOUT_EN
  localparam int TW = $clog2(L1_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign l1_timeout = 1'b0;
`endif

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      l1_seen     <= 1'b0;
      l1_acc      <= 1'b0;
      busy        <= 1'b0;
      evt_dropped <= 1'b0;
      evt_count   <= '0;
      drop_count  <= '0;
`ifdef EVENT_BUF_CTRL_L1_TIMEOUT_EN
      tmo_cnt     <= '0;
      l1_timeout  <= 1'b0;
`endif
    end else begin
      evt_dropped <= 1'b0;
`ifdef EVENT_BUF_CTRL_L1_TIMEOUT_EN
      l1_timeout  <= 1'b0;
`endif
      if (bus.trig_l0 && (state != IDLE)) begin
        evt_dropped <= 1'b1;
        drop_count  <= drop_count + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.trig_l0) begin
            state   <= CAPTURE;
            wr_en   <= 1'b1;
            wr_addr <= '0;
            l1_seen <= 1'b0;
            l1_acc  <= 1'b0;
            busy    <= 1'b1;
`ifdef EVENT_BUF_CTRL_L1_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        CAPTURE: begin
          wr_addr <= wr_addr + AW'(1);
          if (!l1_seen && l1_pulse) begin
            l1_seen <= 1'b1;
            l1_acc  <= !bus.l1_reject;
          end
          if (wr_addr == LAST_ADDR) begin
            state   <= WAIT_L1;
            wr_en   <= 1'b0;
            wr_addr <= '0;
          end
        end

        WAIT_L1: begin
          if (dec_rej) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dec_acc) begin
            state   <= READOUT;
            rd_addr <= '0;
          end
`ifdef EVENT_BUF_CTRL_L1_TIMEOUT_EN
          else if (tmo_cnt == TW'(L1_TIMEOUT - 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            l1_timeout <= 1'b1;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end

        READOUT: begin
          if (rd_fire) begin
            rd_addr <= rd_addr + AW'(1);
          end
          if (rd_fire_last) begin
            state   <= DRAIN;
            rd_addr <= '0;
          end
        end

        // Wait for the final word to emerge from the buffer read pipeline.
        DRAIN: begin
          if (bus.rd_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            evt_count <= evt_count + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/event_buf_ctrl.md
EVENT_BUF_CTRL -- requirements
Module: event_buf_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, 64, samples per event (addresses 0..DEPTH-1); AW, 6, address width; RD_LAT, 2, event buffer read latency in cycles; L1_TIMEOUT, 1000, WAIT_L1 cycle limit; CNT_W, 16, counter width.
REQ-002 adc_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 trig_l0  in  1  level-0 trigger, one-cycle pulse.
REQ-005 l1_accept  in  1  level-1 accept pulse.
REQ-006 l1_reject  in  1  level-1 reject pulse.
REQ-007 rd_ready  in  1  downstream has room for at least RD_LAT+1 words.
REQ-008 mem_wr_en  out  1  buffer write enable.
REQ-009 mem_wr_addr  out  AW  buffer write address.
REQ-010 mem_rd_en  out  1  buffer read enable.
REQ-011 mem_rd_addr  out  AW  buffer read address.
REQ-012 rd_valid  out  1  buffer output word valid this cycle.
REQ-013 rd_last  out  1  marks the final word (address DEPTH-1) of an event.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 evt_dropped  out  1  one-cycle pulse when trig_l0 is ignored.
REQ-016 l1_timeout  out  1  one-cycle pulse on L1 timeout.
REQ-017 evt_count  out  CNT_W  number of fully read events; wraps at 2^CNT_W.
REQ-018 drop_count  out  CNT_W  number of dropped L0 triggers; wraps at 2^CNT_W.

Function
REQ-019 States SHALL be IDLE, CAPTURE, WAIT_L1, READOUT and DRAIN.
REQ-020 IDLE + trig_l0 -> CAPTURE next cycle; mem_wr_en high for exactly DEPTH consecutive cycles, mem_wr_addr 0,1,...,DEPTH-1.
REQ-021 CAPTURE SHALL go to WAIT_L1 the cycle after address DEPTH-1 is written; mem_wr_en low outside CAPTURE.
REQ-022 The first l1_accept/l1_reject seen in CAPTURE or WAIT_L1 SHALL be latched; later L1 pulses for the same event are ignored; accept and reject in the same cycle counts as reject.
REQ-023 WAIT_L1 with a latched or current reject -> IDLE; with an accept -> READOUT; otherwise it stays in WAIT_L1.
REQ-024 In READOUT, mem_rd_en = rd_ready; mem_rd_addr starts at 0 and increments only on cycles with mem_rd_en high.
REQ-025 A read issued at mem_rd_addr DEPTH-1 -> DRAIN next cycle; mem_rd_en low outside READOUT.
REQ-026 rd_valid SHALL equal mem_rd_en delayed exactly RD_LAT cycles; rd_last SHALL equal (mem_rd_en and mem_rd_addr==DEPTH-1) delayed RD_LAT cycles.
REQ-027 DRAIN SHALL go to IDLE in the cycle rd_last is high; evt_count increments in that cycle.
REQ-028 trig_l0 in any state other than IDLE SHALL be ignored, pulse evt_dropped and increment drop_count (saturation not applied).
REQ-029 trig_l0 in the same cycle DRAIN exits to IDLE SHALL be dropped; acceptance needs state==IDLE at sampling.
REQ-030 busy SHALL be registered from the state and SHALL rise the cycle after the accepted trig_l0.

Reset
REQ-031 rst SHALL force IDLE and zero all outputs, address counters, the L1 latch, the timeout counter, the rd_valid/rd_last pipeline and both counters on the next edge.
REQ-032 rst asserted mid-CAPTURE or mid-READOUT SHALL abort the event with no further writes, reads or rd_valid pulses.

Configuration
REQ-033 Macro EVENT_BUF_CTRL_L1_TIMEOUT_EN defined: the WAIT_L1 cycle counter reaching L1_TIMEOUT with no decision -> IDLE, l1_timeout pulses one cycle, no evt_count change.
REQ-034 Macro not defined: WAIT_L1 waits indefinitely; l1_timeout is tied to 0; no timeout counter is synthesised.

Verification
REQ-035 trig_l0 at cycle 10, l1_accept at cycle 80, rd_ready=1 -> writes at cycles 11..74 (addresses 0..63); reads at addresses 0..63 on consecutive cycles; 64 rd_valid with rd_last on the 64th; evt_count=1; busy falls.
REQ-036 Accept event with rd_ready toggling 1/0 each cycle -> reads take 128 cycles; rd_valid pattern is the rd_ready pattern delayed 2 cycles; addresses are never skipped or repeated.
REQ-037 l1_accept and l1_reject in the same cycle during CAPTURE -> WAIT_L1 exits to IDLE; no reads; evt_count unchanged.
REQ-038 trig_l0 pulses at cycles 20 and 50 of one event -> two evt_dropped pulses; drop_count=2; write addresses are unaffected.
REQ-039 With EVENT_BUF_CTRL_L1_TIMEOUT_EN and L1_TIMEOUT=1000, no L1 -> l1_timeout pulses 1000 cycles after WAIT_L1 entry, then IDLE; without the macro, still in WAIT_L1 after 5000 cycles.
REQ-040 rst at read address 30 -> IDLE next cycle; mem_rd_en and rd_valid stay 0 after reset; evt_count=0; a new trig_l0 starts writing at address 0.
